// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and length-lookup record.
package midi_pkg;

    localparam logic [7:0] NOTE_OFF = 8'h80;
    localparam logic [7:0] NOTE_ON  = 8'h90;
    localparam logic [7:0] CC       = 8'hB0;
    localparam logic [7:0] PROG     = 8'hC0;
    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] TUNE_REQ = 8'hF6;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] RT_BASE  = 8'hF8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_D1,
        ST_WAIT_D2,
        ST_SYSEX
    } state_e;

    typedef struct packed {
        logic [1:0] needed_len;
        logic       clears_running;
        logic       undefined;
    } len_info_t;

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle between the UART receiver, parser and consumer.
interface midi_msg_parser_if;

    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       msg_valid;
    logic       msg_ack;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic [1:0] msg_len;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic       overrun;
    logic       stray;
    logic       err_clear;

    modport master (
        output rx_byte, rx_strobe, msg_ack, err_clear,
        input  msg_valid, msg_status, msg_data1, msg_data2, msg_len,
               rt_valid, rt_byte, overrun, stray
    );

    modport slave (
        input  rx_byte, rx_strobe, msg_ack, err_clear,
        output msg_valid, msg_status, msg_data1, msg_data2, msg_len,
               rt_valid, rt_byte, overrun, stray
    );

endinterface

// File: rtl/midi_len_lut.sv
// Status byte classification: data bytes needed, running-status clear, undefined code.
module midi_len_lut
    import midi_pkg::*;
(
    input  logic [7:0] status_i,
    output len_info_t  info_o
);

    always_comb begin
        info_o = '0;
        case (status_i[7:4])
            NOTE_OFF[7:4], NOTE_ON[7:4], 4'hA, CC[7:4], 4'hE: info_o.needed_len = 2'd2;
            PROG[7:4], 4'hD:                                  info_o.needed_len = 2'd1;
            SYSEX[7:4]: begin
                info_o.clears_running = (status_i < RT_BASE);
                case (status_i[3:0])
                    4'h1, 4'h3:             info_o.needed_len = 2'd1;
                    4'h2:                   info_o.needed_len = 2'd2;
                    4'h4, 4'h5, 4'h9, 4'hD: info_o.undefined  = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, SysEx skipping, real-time bypass,
// and a valid/ack message register with sticky overrun.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter bit PASS_SYSEX_END = 1'b0
)(
    input logic             clk50MHz,
    input logic             reset_n,
    midi_msg_parser_if.slave bus
);

    logic [7:0] rx_b;
    len_info_t  info;

    state_e     state_q, state_d;
    logic       rs_valid_q, rs_valid_d;
    logic [7:0] cur_status_q, cur_status_d;
    logic [1:0] cur_len_q, cur_len_d;
    logic [6:0] d1_q, d1_d;

    logic       emit_d, stray_d, rt_d;
    logic [7:0] emit_status_d;
    logic [6:0] emit_d1_d, emit_d2_d;
    logic [1:0] emit_len_d;

    logic       msg_valid_q, rt_valid_q, overrun_q, stray_q;
    logic [7:0] msg_status_q, rt_byte_q;
    logic [6:0] msg_data1_q, msg_data2_q;
    logic [1:0] msg_len_q;

    assign rx_b = bus.rx_byte;

    midi_len_lut u_len_lut (
        .status_i (rx_b),
        .info_o   (info)
    );

    // cur_status_q always equals the running status while rs_valid_q is set,
    // so running-status messages reuse the current-message registers.
    always_comb begin
        state_d       = state_q;
        rs_valid_d    = rs_valid_q;
        cur_status_d  = cur_status_q;
        cur_len_d     = cur_len_q;
        d1_d          = d1_q;
        emit_d        = 1'b0;
        emit_status_d = cur_status_q;
        emit_d1_d     = d1_q;
        emit_d2_d     = '0;
        emit_len_d    = cur_len_q;
        stray_d       = 1'b0;
        rt_d          = 1'b0;
        if (bus.rx_strobe) begin
            if (rx_b >= RT_BASE) begin
                rt_d = 1'b1;
            end else if (rx_b[7]) begin
                rs_valid_d = ~info.clears_running;
                if (info.undefined || (rx_b == EOX && state_q != ST_SYSEX)) begin
                    stray_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (rx_b == EOX) begin
                    emit_d        = PASS_SYSEX_END;
                    emit_status_d = EOX;
                    emit_d1_d     = '0;
                    emit_len_d    = 2'd0;
                    state_d       = ST_IDLE;
                end else if (rx_b == SYSEX) begin
                    state_d = ST_SYSEX;
                end else if (rx_b == TUNE_REQ) begin
                    emit_d        = 1'b1;
                    emit_status_d = TUNE_REQ;
                    emit_d1_d     = '0;
                    emit_len_d    = 2'd0;
                    state_d       = ST_IDLE;
                end else begin
                    cur_status_d = rx_b;
                    cur_len_d    = info.needed_len;
                    state_d      = ST_WAIT_D1;
                end
            end else if (state_q == ST_WAIT_D2) begin
                emit_d     = 1'b1;
                emit_d2_d  = rx_b[6:0];
                emit_len_d = 2'd2;
                state_d    = ST_IDLE;
            end else if (state_q == ST_WAIT_D1 || (state_q == ST_IDLE && rs_valid_q)) begin
                if (cur_len_q == 2'd1) begin
                    emit_d     = 1'b1;
                    emit_d1_d  = rx_b[6:0];
                    emit_len_d = 2'd1;
                    state_d    = ST_IDLE;
                end else begin
                    d1_d    = rx_b[6:0];
                    state_d = ST_WAIT_D2;
                end
            end else if (state_q == ST_IDLE) begin
                stray_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rs_valid_q   <= 1'b0;
            cur_status_q <= '0;
            cur_len_q    <= '0;
            d1_q         <= '0;
            msg_valid_q  <= 1'b0;
            msg_status_q <= '0;
            msg_data1_q  <= '0;
            msg_data2_q  <= '0;
            msg_len_q    <= '0;
            rt_valid_q   <= 1'b0;
            rt_byte_q    <= '0;
            overrun_q    <= 1'b0;
            stray_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs_valid_q   <= rs_valid_d;
            cur_status_q <= cur_status_d;
            cur_len_q    <= cur_len_d;
            d1_q         <= d1_d;
            rt_valid_q   <= rt_d;
            stray_q      <= stray_d;
            if (rt_d) rt_byte_q <= rx_b;

            if (emit_d && (!msg_valid_q || bus.msg_ack)) begin
                msg_valid_q  <= 1'b1;
                msg_status_q <= emit_status_d;
                msg_data1_q  <= emit_d1_d;
                msg_data2_q  <= emit_d2_d;
                msg_len_q    <= emit_len_d;
            end else if (bus.msg_ack) begin
                msg_valid_q <= 1'b0;
            end

            // A dropped message outranks a simultaneous clear.
            if (emit_d && msg_valid_q && !bus.msg_ack) overrun_q <= 1'b1;
            else if (bus.err_clear)                    overrun_q <= 1'b0;
        end
    end

    assign bus.msg_valid  = msg_valid_q;
    assign bus.msg_status = msg_status_q;
    assign bus.msg_data1  = msg_data1_q;
    assign bus.msg_data2  = msg_data2_q;
    assign bus.msg_len    = msg_len_q;
    assign bus.rt_valid   = rt_valid_q;
    assign bus.rt_byte    = rt_byte_q;
    assign bus.overrun    = overrun_q;
    assign bus.stray      = stray_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed vector table plus randomized byte stream against a message-level model.
module tb_midi_msg_parser;

    localparam bit TB_PASS = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #10 clk = ~clk;

    midi_msg_parser_if bus ();

    midi_msg_parser #(.PASS_SYSEX_END(TB_PASS)) dut (
        .clk50MHz (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Message-level reference model
    logic [7:0] m_rs;        // 0 means no running status
    logic [7:0] m_cur;
    int         m_need;
    logic [6:0] m_pend[$];
    bit         m_in_msg, m_sysex;
    bit         m_v, m_ovr, m_rt, m_stray;
    logic [7:0] m_st, m_rtb;
    logic [6:0] m_d1, m_d2;
    logic [1:0] m_len;

    function automatic int need_of(input logic [7:0] s);
        return (s >= 8'hC0 && s < 8'hE0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_rs = 0; m_cur = 0; m_need = 0; m_pend.delete();
        m_in_msg = 0; m_sysex = 0;
        m_v = 0; m_ovr = 0; m_rt = 0; m_stray = 0;
        m_st = 0; m_rtb = 0; m_d1 = 0; m_d2 = 0; m_len = 0;
    endtask

    task automatic model_step(input bit stb, input logic [7:0] b, input bit ack, input bit clr);
        bit         emit = 0;
        bit         was_sx, set_ovr;
        logic [7:0] es = 0;
        logic [6:0] e1 = 0, e2 = 0;
        logic [1:0] el = 0;
        m_rt = 0; m_stray = 0;
        if (stb) begin
            if (b >= 8'hF8) begin
                m_rt = 1; m_rtb = b;
            end else if (b >= 8'h80 && b < 8'hF0) begin
                m_rs = b; m_cur = b; m_need = need_of(b);
                m_pend.delete(); m_in_msg = 1; m_sysex = 0;
            end else if (b >= 8'hF0) begin
                was_sx = m_sysex;
                m_rs = 0; m_pend.delete(); m_in_msg = 0; m_sysex = 0;
                case (b)
                    8'hF0: m_sysex = 1;
                    8'hF1, 8'hF3: begin m_cur = b; m_need = 1; m_in_msg = 1; end
                    8'hF2: begin m_cur = b; m_need = 2; m_in_msg = 1; end
                    8'hF6: begin emit = 1; es = b; end
                    8'hF7: begin
                        if (!was_sx) m_stray = 1;
                        else if (TB_PASS) begin emit = 1; es = b; end
                    end
                    default: m_stray = 1;
                endcase
            end else if (!m_sysex) begin
                if (!m_in_msg && m_rs != 0) begin
                    m_cur = m_rs; m_need = need_of(m_rs); m_in_msg = 1;
                end
                if (m_in_msg) begin
                    m_pend.push_back(b[6:0]);
                    if (m_pend.size() == m_need) begin
                        emit = 1; es = m_cur; e1 = m_pend[0];
                        e2 = (m_need == 2) ? m_pend[1] : 7'd0;
                        el = 2'(m_need);
                        m_pend.delete(); m_in_msg = 0;
                    end
                end else begin
                    m_stray = 1;
                end
            end
        end
        set_ovr = emit && m_v && !ack;
        if (emit && (!m_v || ack)) begin
            m_v = 1; m_st = es; m_d1 = e1; m_d2 = e2; m_len = el;
        end else if (ack) begin
            m_v = 0;
        end
        if (set_ovr)  m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic step(input bit stb, input logic [7:0] b, input bit ack, input bit clr);
        bus.rx_strobe = stb; bus.rx_byte = b; bus.msg_ack = ack; bus.err_clear = clr;
        @(posedge clk); #1;
        model_step(stb, b, ack, clr);
        bus.rx_strobe = 0; bus.msg_ack = 0; bus.err_clear = 0;
    endtask

    task automatic check_model();
        chk("msg_valid", 32'(bus.msg_valid), 32'(m_v));
        if (m_v) begin
            chk("msg_status", 32'(bus.msg_status), 32'(m_st));
            chk("msg_data1",  32'(bus.msg_data1),  32'(m_d1));
            chk("msg_data2",  32'(bus.msg_data2),  32'(m_d2));
            chk("msg_len",    32'(bus.msg_len),    32'(m_len));
        end
        chk("overrun",  32'(bus.overrun),  32'(m_ovr));
        chk("rt_valid", 32'(bus.rt_valid), 32'(m_rt));
        chk("rt_byte",  32'(bus.rt_byte),  32'(m_rtb));
        chk("stray",    32'(bus.stray),    32'(m_stray));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_msg_valid"},  32'(bus.msg_valid),  0);
        chk({tag, "_msg_status"}, 32'(bus.msg_status), 0);
        chk({tag, "_msg_data1"},  32'(bus.msg_data1),  0);
        chk({tag, "_msg_data2"},  32'(bus.msg_data2),  0);
        chk({tag, "_msg_len"},    32'(bus.msg_len),    0);
        chk({tag, "_rt_valid"},   32'(bus.rt_valid),   0);
        chk({tag, "_rt_byte"},    32'(bus.rt_byte),    0);
        chk({tag, "_overrun"},    32'(bus.overrun),    0);
        chk({tag, "_stray"},      32'(bus.stray),      0);
    endtask

    typedef struct {
        bit         stb;
        logic [7:0] b;
        bit         ack, clr;
        bit         v;
        logic [7:0] st;
        logic [6:0] d1, d2;
        logic [1:0] len;
        bit         rt, stray, ovr;
    } vec_t;

    function automatic vec_t V(bit stb, logic [7:0] b, bit ack, bit clr, bit v,
                               logic [7:0] st, logic [6:0] d1, logic [6:0] d2,
                               logic [1:0] len, bit rt, bit stray, bit ovr);
        vec_t r;
        r.stb = stb; r.b = b; r.ack = ack; r.clr = clr; r.v = v; r.st = st;
        r.d1 = d1; r.d2 = d2; r.len = len; r.rt = rt; r.stray = stray; r.ovr = ovr;
        return r;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        bus.rx_strobe = 0; bus.rx_byte = 0; bus.msg_ack = 0; bus.err_clear = 0;

        // stb b ack clr | v st d1 d2 len | rt stray ovr
        tbl.push_back(V(1, 8'h90, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h3C, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h64, 0, 0, 1, 8'h90, 7'h3C, 7'h64, 2, 0, 0, 0));
        tbl.push_back(V(1, 8'h3E, 1, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h40, 1, 0, 1, 8'h90, 7'h3E, 7'h40, 2, 0, 0, 0));
        tbl.push_back(V(0, 8'h00, 1, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'hC5, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h07, 0, 0, 1, 8'hC5, 7'h07, 7'h00, 1, 0, 0, 0));
        tbl.push_back(V(1, 8'hB0, 1, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'hF8, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 1, 0, 0));
        tbl.push_back(V(1, 8'h07, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h7F, 0, 0, 1, 8'hB0, 7'h07, 7'h7F, 2, 0, 0, 0));
        tbl.push_back(V(0, 8'h00, 1, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'hF0, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h01, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h02, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h90, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h3C, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h00, 0, 0, 1, 8'h90, 7'h3C, 7'h00, 2, 0, 0, 0));
        tbl.push_back(V(0, 8'h00, 1, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'hF0, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h05, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'hF7, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h3C, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 1, 0));
        tbl.push_back(V(1, 8'h90, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h3C, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h64, 0, 0, 1, 8'h90, 7'h3C, 7'h64, 2, 0, 0, 0));
        tbl.push_back(V(1, 8'h3E, 0, 0, 1, 8'h90, 7'h3C, 7'h64, 2, 0, 0, 0));
        tbl.push_back(V(1, 8'h40, 0, 0, 1, 8'h90, 7'h3C, 7'h64, 2, 0, 0, 1));
        tbl.push_back(V(0, 8'h00, 0, 1, 1, 8'h90, 7'h3C, 7'h64, 2, 0, 0, 0));
        tbl.push_back(V(1, 8'h41, 0, 0, 1, 8'h90, 7'h3C, 7'h64, 2, 0, 0, 0));
        tbl.push_back(V(1, 8'h42, 1, 0, 1, 8'h90, 7'h41, 7'h42, 2, 0, 0, 0));
        tbl.push_back(V(0, 8'h00, 1, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h43, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h44, 0, 0, 1, 8'h90, 7'h43, 7'h44, 2, 0, 0, 0));
        tbl.push_back(V(1, 8'h45, 0, 0, 1, 8'h90, 7'h43, 7'h44, 2, 0, 0, 0));
        tbl.push_back(V(1, 8'h46, 0, 1, 1, 8'h90, 7'h43, 7'h44, 2, 0, 0, 1));
        tbl.push_back(V(0, 8'h00, 1, 1, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'hF6, 0, 0, 1, 8'hF6, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(0, 8'h00, 1, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'hF4, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 1, 0));
        tbl.push_back(V(1, 8'hF9, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 1, 0, 0));
        tbl.push_back(V(1, 8'h3C, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 1, 0));
        tbl.push_back(V(1, 8'hF1, 0, 0, 0, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0));
        tbl.push_back(V(1, 8'h25, 0, 0, 1, 8'hF1, 7'h25, 7'h00, 1, 0, 0, 0));

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset("reset");
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].stb, tbl[i].b, tbl[i].ack, tbl[i].clr);
            chk($sformatf("v%0d_valid", i), 32'(bus.msg_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("v%0d_status", i), 32'(bus.msg_status), 32'(tbl[i].st));
                chk($sformatf("v%0d_data1", i),  32'(bus.msg_data1),  32'(tbl[i].d1));
                chk($sformatf("v%0d_data2", i),  32'(bus.msg_data2),  32'(tbl[i].d2));
                chk($sformatf("v%0d_len", i),    32'(bus.msg_len),    32'(tbl[i].len));
            end
            chk($sformatf("v%0d_rt_valid", i), 32'(bus.rt_valid), 32'(tbl[i].rt));
            if (tbl[i].rt)
                chk($sformatf("v%0d_rt_byte", i), 32'(bus.rt_byte), 32'(tbl[i].b));
            chk($sformatf("v%0d_stray", i),   32'(bus.stray),   32'(tbl[i].stray));
            chk($sformatf("v%0d_overrun", i), 32'(bus.overrun), 32'(tbl[i].ovr));
        end

        // Reset in the middle of a message discards it and the running status.
        step(1, 8'h90, 0, 0);
        step(1, 8'h3C, 0, 0);
        #3 rst_n = 1'b0;
        #1 check_reset("midreset");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step(1, 8'h40, 0, 0);
        chk("after_reset_stray", 32'(bus.stray), 1);
        chk("after_reset_valid", 32'(bus.msg_valid), 0);
        step(0, 8'h00, 0, 0);
        chk("after_reset_idle_valid", 32'(bus.msg_valid), 0);

        for (int unsigned n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [7:0]  b;
            bit          stb, ack, clr;
            r = $urandom_range(0, 99);
            if (r < 50)      b = 8'($urandom_range(8'h00, 8'h7F));
            else if (r < 75) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 88) b = 8'($urandom_range(8'hF0, 8'hF7));
            else             b = 8'($urandom_range(8'hF8, 8'hFF));
            stb = ($urandom_range(0, 9) < 7);
            ack = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 9) == 0);
            step(stb, b, ack, clr);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
